spi_frame_receiver: RTL and testbench

PLC-side deserializer for the 32-bit encoder frames produced by the SSI-encoder/SPI transmitter stage. It oversamples the incoming `spi_clk`/`spi_mosi` pair in the local `clk` domain and delimits frames by bus-idle timeout, since the link has no chip select. Each frame is checked for the 0xAA header, optionally Gray-decoded, and the 24-bit position is presented on a valid/ready interface to downstream control logic. Protocol errors are counted.

---
 rtl/plk_encoder_pkg.sv | 30 +++
 rtl/spi_frame_receiver_if.sv | 19 +
 rtl/spi_frame_receiver_sync_edge_detect.sv | 28 ++
 rtl/spi_frame_receiver.sv | 161 ++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/plk_encoder_pkg.sv
// Shared constants and types for the encoder link (transmitter and PLC-side
// receiver both import this package).
//   FRAME_BITS : bits per serial frame
//   POS_BITS   : width of the position field, frame bits [POS_BITS-1:0]
//   HEADER     : required value of frame bits [31:24]
//   rx_state_t : receiver FSM state encoding
//   gray2bin   : Gray-to-binary conversion of a position word
package plk_encoder_pkg;

  localparam int         FRAME_BITS = 32;
  localparam int         POS_BITS   = 24;
  localparam logic [7:0] HEADER     = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

  // Each binary bit is the XOR of the Gray bit and the binary bit above it.
  function automatic logic [POS_BITS-1:0] gray2bin(input logic [POS_BITS-1:0] g);
    logic [POS_BITS-1:0] b;
    b[POS_BITS-1] = g[POS_BITS-1];
    for (int i = POS_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Position output channel of the frame receiver.
//   pos_data  : position word, valid while pos_valid is high
//   pos_valid : a new, unconsumed position is presented
//   pos_ready : consumer can take pos_data this cycle
// Handshake: a word transfers on every rising clk edge where pos_valid and
// pos_ready are both high. pos_valid is set by the producer and only cleared
// by a transfer; pos_data is stable while pos_valid is high unless a newer
// frame overwrites it (reported separately as overrun). pos_ready may be
// driven freely and does not depend on pos_valid.
interface spi_frame_receiver_if;
  import plk_encoder_pkg::*;

  logic [POS_BITS-1:0] pos_data;
  logic                pos_valid;
  logic                pos_ready;

  modport master (output pos_data, output pos_valid, input pos_ready);
  modport slave  (input pos_data, input pos_valid, output pos_ready);
endinterface

// File: rtl/spi_frame_receiver_sync_edge_detect.sv
// Two-flop synchronizer with a rising-edge strobe.
//   clk  : local clock
//   rst  : asynchronous active-high reset
//   din  : asynchronous input
//   rise : one-cycle strobe after a 0->1 transition of din has been
//          synchronized (aligned with the second synchronizer stage)
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/spi_frame_receiver.sv
// Deserializer for 32-bit encoder frames arriving on an spi_clk/spi_mosi
// pair without chip select. Frames are delimited by an idle gap on spi_clk,
// checked for header and length, optionally Gray-decoded, and the position
// is offered on a valid/ready channel.
//   clk, rst    : local clock, asynchronous active-high reset
//   spi_clk     : serial clock, asynchronous to clk
//   spi_mosi    : serial data (LSB first), asynchronous to clk
//   pos         : position channel (pos_data / pos_valid / pos_ready)
//   frame_err   : one-cycle pulse on a rejected frame
//   overrun     : one-cycle pulse when an unconsumed position is replaced
//   err_count   : rejected-frame count, saturating at 16'hFFFF
//   state_dbg   : current FSM state
module spi_frame_receiver
  import plk_encoder_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int GRAY_DECODE  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_clk,
  input  logic                        spi_mosi,
  spi_frame_receiver_if.master        pos,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [15:0]                 err_count,
  output rx_state_t                   state_dbg
);
  localparam int             IW        = $clog2(IDLE_TIMEOUT);
  // The state register moves to CHECK on the same edge that idle_cnt
  // reaches IDLE_TIMEOUT-1, so the decision is taken one count earlier.
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_TIMEOUT - 2);
  localparam logic [5:0]     CNT_MAX   = 6'd63;
  localparam logic [5:0]     CNT_FRAME = 6'(FRAME_BITS);

  // Synchronizers: data gets the same two-stage delay as the clock strobe.
  logic clk_rise;
  logic mosi_s1_q, mosi_s2_q;

  sync_edge_detect u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_clk),
    .rise (clk_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  rx_state_t               state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic [POS_BITS-1:0]     pos_data_q, pos_data_d;
  logic                    pos_valid_q, pos_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             err_count_q, err_count_d;
  logic                    frame_good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      pos_data_q  <= '0;
      pos_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      pos_data_q  <= pos_data_d;
      pos_valid_q <= pos_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign frame_good = (bit_cnt_q == CNT_FRAME) &&
                      (sr_q[FRAME_BITS-1 -: 8] == HEADER);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    pos_data_d  = pos_data_q;
    pos_valid_d = pos_valid_q && !pos.pos_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (clk_rise) begin
          // sr is all-zero here, so shifting places the first bit at the MSB.
          sr_d      = {mosi_s2_q, sr_q[FRAME_BITS-1:1]};
          bit_cnt_d = 6'd1;
          idle_d    = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (clk_rise) begin
          sr_d      = {mosi_s2_q, sr_q[FRAME_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + 6'd1;
          idle_d    = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_LAST) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        // Any spi_clk edge seen in this cycle is dropped.
        if (frame_good) begin
          pos_data_d  = (GRAY_DECODE != 0) ? gray2bin(sr_q[POS_BITS-1:0])
                                           : sr_q[POS_BITS-1:0];
          pos_valid_d = 1'b1;
          overrun_d   = pos_valid_q && !pos.pos_ready;
        end else begin
          frame_err_d = 1'b1;
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
        end
        sr_d      = '0;
        bit_cnt_d = '0;
        idle_d    = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pos.pos_data  = pos_data_q;
  assign pos.pos_valid = pos_valid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign err_count     = err_count_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: one binary instance and one Gray-decoding
// instance share the same serial link. Expected positions are queued when a
// frame is sent; monitors pop them on accepted transfers.
module tb_spi_frame_receiver;
  import plk_encoder_pkg::*;

  localparam int IDLE_TIMEOUT = 64;
  // Pin edge -> output visible: 2 synchronizer stages, then IDLE_TIMEOUT+1.
  localparam int LAT = IDLE_TIMEOUT + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  spi_frame_receiver_if bin_if();
  spi_frame_receiver_if gry_if();

  logic        frame_err_b, overrun_b, frame_err_g, overrun_g;
  logic [15:0] err_count_b, err_count_g;
  rx_state_t   state_b, state_g;

  spi_frame_receiver #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .GRAY_DECODE(0)) dut_bin (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .pos(bin_if), .frame_err(frame_err_b), .overrun(overrun_b),
    .err_count(err_count_b), .state_dbg(state_b)
  );

  spi_frame_receiver #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .GRAY_DECODE(1)) dut_gry (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .pos(gry_if), .frame_err(frame_err_g), .overrun(overrun_g),
    .err_count(err_count_g), .state_dbg(state_g)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_b_q[$];
  logic [23:0] exp_g_q[$];
  int err_pend_b = 0, err_pend_g = 0;
  int exp_err_cnt = 0;
  int exp_overrun_b = 0;
  int seen_overrun_b = 0, seen_overrun_g = 0;
  int last_edge_cyc = 0;
  bit hold_b = 1'b0;
  bit pend_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Gray to binary as a prefix XOR of right shifts.
  function automatic logic [23:0] ref_gray2bin(input logic [23:0] g);
    logic [23:0] b;
    b = g;
    for (int s = 1; s < 24; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // ---------------- consumer drivers ----------------
  initial begin
    gry_if.pos_ready = 1'b1;
    bin_if.pos_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bin_if.pos_ready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitors ----------------
  logic prev_valid_b = 1'b0, prev_valid_g = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid_b = 1'b0;
    end else begin
      if (overrun_b) seen_overrun_b++;
      if (frame_err_b) begin
        check("bin_err_latency", 32'(cyc - last_edge_cyc), 32'(LAT));
        if (err_pend_b == 0) flag("bin_frame_err");
        else err_pend_b--;
      end
      if (bin_if.pos_valid && !prev_valid_b)
        check("bin_valid_latency", 32'(cyc - last_edge_cyc), 32'(LAT));
      if (bin_if.pos_valid && bin_if.pos_ready) begin
        if (exp_b_q.size() == 0) flag("bin_accept");
        else check("bin_pos_data", 32'(bin_if.pos_data), 32'(exp_b_q.pop_front()));
      end
      prev_valid_b = bin_if.pos_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_valid_g = 1'b0;
    end else begin
      if (overrun_g) seen_overrun_g++;
      if (frame_err_g) begin
        if (err_pend_g == 0) flag("gry_frame_err");
        else err_pend_g--;
      end
      if (gry_if.pos_valid && !prev_valid_g)
        check("gry_valid_latency", 32'(cyc - last_edge_cyc), 32'(LAT));
      if (gry_if.pos_valid && gry_if.pos_ready) begin
        if (exp_g_q.size() == 0) flag("gry_accept");
        else check("gry_pos_data", 32'(gry_if.pos_data), 32'(exp_g_q.pop_front()));
      end
      prev_valid_g = gry_if.pos_valid;
    end
  end

  // ---------------- stimulus drivers ----------------
  task automatic send_bits(input logic [63:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[i];
      repeat (half) @(negedge clk);
      spi_clk = 1'b1;
      last_edge_cyc = cyc;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int half);
    logic [23:0] p;
    if (n == FRAME_BITS && bits[31:24] == HEADER) begin
      p = bits[23:0];
      if (hold_b && pend_b) begin
        exp_b_q[exp_b_q.size() - 1] = p;
        exp_overrun_b++;
      end else begin
        exp_b_q.push_back(p);
      end
      if (hold_b) pend_b = 1'b1;
      exp_g_q.push_back(ref_gray2bin(p));
    end else begin
      err_pend_b++;
      err_pend_g++;
      if (exp_err_cnt < 65535) exp_err_cnt++;
    end
    send_bits(bits, n, half);
    repeat (LAT + 20) @(negedge clk);
    check("bin_err_count", 32'(err_count_b), 32'(exp_err_cnt));
    check("gry_err_count", 32'(err_count_g), 32'(exp_err_cnt));
  endtask

  task automatic check_reset_state();
    check("rst_bin_valid", 32'(bin_if.pos_valid), 32'd0);
    check("rst_bin_data", 32'(bin_if.pos_data), 32'd0);
    check("rst_bin_errcnt", 32'(err_count_b), 32'd0);
    check("rst_bin_frame_err", 32'(frame_err_b), 32'd0);
    check("rst_bin_overrun", 32'(overrun_b), 32'd0);
    check("rst_bin_state", 32'(state_b), 32'(ST_IDLE));
    check("rst_gry_valid", 32'(gry_if.pos_valid), 32'd0);
    check("rst_gry_errcnt", 32'(err_count_g), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] w;
    int kind, n, half;

    repeat (5) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed frames.
    send_frame(64'hAA12_3456, 32, 4);
    send_frame(64'hAB12_3456, 32, 4);
    send_frame(64'h2A12_3456, 31, 4);
    send_frame(64'h1_AA12_3456, 33, 4);
    send_frame(64'hAA00_0003, 32, 4);
    send_frame(64'hAA80_0000, 32, 5);

    // Overrun: consumer stalled across two good frames.
    hold_b = 1'b1;
    pend_b = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(64'hAA00_0001, 32, 4);
    send_frame(64'hAA00_0002, 32, 4);
    check("overrun_pulses", 32'(seen_overrun_b), 32'd1);
    hold_b = 1'b0;
    pend_b = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized traffic.
    for (int f = 0; f < 20; f++) begin
      kind = $urandom_range(0, 9);
      half = $urandom_range(4, 7);
      w = {$urandom(), $urandom()};
      n = 32;
      if (kind <= 5 || kind == 9) begin
        w[31:24] = HEADER;
      end else if (kind == 6) begin
        if (w[31:24] == HEADER) w[31:24] = 8'h55;
      end else if (kind == 7) begin
        w[31:24] = HEADER;
        n = $urandom_range(1, 31);
      end else begin
        w[31:24] = HEADER;
        n = $urandom_range(33, 40);
      end
      send_frame(w, n, half);
    end

    // Reset in the middle of a frame discards it silently.
    send_bits(64'hAAAB_CDEF, 16, 4);
    @(negedge clk);
    rst = 1'b1;
    exp_err_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(64'hAAAB_CDEF, 32, 4);

    repeat (20) @(negedge clk);
    check("bin_queue_empty", 32'(exp_b_q.size()), 32'd0);
    check("gry_queue_empty", 32'(exp_g_q.size()), 32'd0);
    check("bin_err_pending", 32'(err_pend_b), 32'd0);
    check("gry_err_pending", 32'(err_pend_g), 32'd0);
    check("bin_overrun_total", 32'(seen_overrun_b), 32'(exp_overrun_b));
    check("gry_overrun_total", 32'(seen_overrun_g), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
